// File: rtl/fpu_defs_fmac.sv
// Shared definitions for the FP32 fused multiply-add normalise/round stage.
// Holds the datapath widths, the FP32 exponent constants and the
// rounding-mode encoding used between the top and the rounding sub-module.
package fpu_defs_fmac;

    localparam int C_WIDTH         = 51;   // unnormalised mantissa, 2*24+3
    localparam int C_LEADONE_WIDTH = 6;
    localparam int C_EXP_W         = 10;   // signed internal exponent
    localparam int C_EXP_BITS      = 8;
    localparam int C_MANT_BITS     = 23;

    localparam int C_EXP_BIAS      = 127;
    localparam int C_EXP_MAX       = 255;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rnd_mode_e;

endpackage

// File: rtl/fmac_round_rne.sv
// Combinational rounding of a 23-bit fraction with an implicit leading one.
// Ports:
//   frac     in   23  fraction bits below the hidden one
//   guard    in   1   first bit below the fraction lsb
//   sticky   in   1   OR of all remaining lower bits
//   rm       in   1   rounding mode (RM_RNE / RM_RTZ)
//   frac_rnd out  23  rounded fraction (zero when the significand carries out)
//   carry    out  1   significand rounded up to 2^24, exponent must increment
//   inexact  out  1   any discarded bit was set
module fmac_round_rne
    import fpu_defs_fmac::*;
(
    input  logic [C_MANT_BITS-1:0] frac,
    input  logic                   guard,
    input  logic                   sticky,
    input  logic                   rm,
    output logic [C_MANT_BITS-1:0] frac_rnd,
    output logic                   carry,
    output logic                   inexact
);

    logic                 inc;
    logic [C_MANT_BITS:0] sum;

    // Round half to even: only round up past the halfway point, or exactly on
    // it when the lsb is odd.
    assign inc = (rm == RM_RNE) & guard & (sticky | frac[0]);

    // The hidden one is included so the carry marks a significand of 2^24;
    // in that case all fraction bits have wrapped to zero.
    assign {carry, sum} = {1'b0, 1'b1, frac} + {{(C_MANT_BITS + 1){1'b0}}, inc};

    assign frac_rnd = sum[C_MANT_BITS-1:0];
    assign inexact  = guard | sticky;

endmodule

// File: rtl/fmac_norm_round.sv
// Normalise/round stage of the FP32 FMA datapath (after the leading-zero count).
// Two register stages with valid/ready handshake:
//   stage 1 : left-normalise the magnitude and adjust the exponent
//   stage 2 : round, detect zero/underflow/overflow, pack the FP32 result
// Ports:
//   Clk_CI, Rst_RI          clock and synchronous active-high reset
//   Valid_SI / Ready_SO     upstream handshake
//   Sign_DI, Exp_DI         sign and biased exponent for Mant_DI[50] as hidden bit
//   Mant_DI, LeadOne_DI     unnormalised magnitude and its leading-zero count
//   NoOne_SI                magnitude is zero (overrides all other fields)
//   Rm_SI                   0 = round to nearest even, 1 = round toward zero
//   Valid_SO / Ready_SI     downstream handshake
//   Result_DO               packed FP32 result
//   OF_SO, UF_SO, NX_SO     overflow, underflow (flush to zero), inexact
module fmac_norm_round
    import fpu_defs_fmac::*;
(
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic                       Valid_SI,
    output logic                       Ready_SO,
    input  logic                       Sign_DI,
    input  logic [C_EXP_W-1:0]         Exp_DI,
    input  logic [C_WIDTH-1:0]         Mant_DI,
    input  logic [C_LEADONE_WIDTH-1:0] LeadOne_DI,
    input  logic                       NoOne_SI,
    input  logic                       Rm_SI,
    output logic                       Valid_SO,
    input  logic                       Ready_SI,
    output logic [31:0]                Result_DO,
    output logic                       OF_SO,
    output logic                       UF_SO,
    output logic                       NX_SO
);

    localparam int LSB_POS = C_WIDTH - 1 - C_MANT_BITS;   // fraction lsb in the normalised word

    localparam logic signed [C_EXP_W-1:0] E_MIN_NORMAL = C_EXP_W'(1);
    localparam logic signed [C_EXP_W:0]   E_OVERFLOW   = (C_EXP_W + 1)'(C_EXP_MAX);

    logic en_1, en_2;
    logic valid_1, valid_o;

    // Stage-1 registers; the hidden bit is dropped since it is always one
    // for a legal non-zero operand.
    logic [C_WIDTH-2:0]         m_1;
    logic signed [C_EXP_W-1:0]  e_1;
    logic                       sign_1, rm_1, zero_1;

    logic [C_WIDTH-2:0]         m_shift;
    logic signed [C_EXP_W-1:0]  e_shift;

    logic [C_MANT_BITS-1:0]     frac_2, frac_rnd;
    logic                       guard_2, sticky_2, carry_2, inexact_2;
    logic signed [C_EXP_W:0]    e_post;

    logic [31:0]                res_nxt;
    logic                       of_nxt, uf_nxt, nx_nxt;

    // A stage may load when it is empty or its content moves on this cycle.
    assign en_2     = ~valid_o | Ready_SI;
    assign en_1     = ~valid_1 | en_2;
    assign Ready_SO = en_1;
    assign Valid_SO = valid_o;

    assign m_shift = (C_WIDTH - 1)'(Mant_DI << LeadOne_DI);
    assign e_shift = $signed(Exp_DI)
                   - $signed({{(C_EXP_W - C_LEADONE_WIDTH){1'b0}}, LeadOne_DI});

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            valid_1 <= 1'b0;
        end else if (en_1) begin
            valid_1 <= Valid_SI;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Valid_SI && en_1) begin
            m_1    <= m_shift;
            e_1    <= e_shift;
            sign_1 <= Sign_DI;
            rm_1   <= Rm_SI;
            zero_1 <= NoOne_SI;
        end
    end

    assign frac_2   = m_1[C_WIDTH-2 -: C_MANT_BITS];
    assign guard_2  = m_1[LSB_POS-1];
    assign sticky_2 = |m_1[LSB_POS-2:0];

    fmac_round_rne u_round (
        .frac     (frac_2),
        .guard    (guard_2),
        .sticky   (sticky_2),
        .rm       (rm_1),
        .frac_rnd (frac_rnd),
        .carry    (carry_2),
        .inexact  (inexact_2)
    );

    // One extra bit so exponent 511 plus a rounding carry cannot wrap.
    assign e_post = {e_1[C_EXP_W-1], e_1} + {{C_EXP_W{1'b0}}, carry_2};

    always_comb begin
        res_nxt = {sign_1, 31'b0};
        of_nxt  = 1'b0;
        uf_nxt  = 1'b0;
        nx_nxt  = 1'b0;
        if (zero_1) begin
            res_nxt = {sign_1, 31'b0};
        end else if (e_1 < E_MIN_NORMAL) begin
            // No subnormal support: anything below the normal range flushes.
            uf_nxt = 1'b1;
            nx_nxt = 1'b1;
        end else if (e_post >= E_OVERFLOW) begin
            of_nxt = 1'b1;
            nx_nxt = 1'b1;
            if (rm_1 == RM_RTZ) begin
                res_nxt = {sign_1, {(C_EXP_BITS - 1){1'b1}}, 1'b0, {C_MANT_BITS{1'b1}}};
            end else begin
                res_nxt = {sign_1, {C_EXP_BITS{1'b1}}, {C_MANT_BITS{1'b0}}};
            end
        end else begin
            res_nxt = {sign_1, e_post[C_EXP_BITS-1:0], frac_rnd};
            nx_nxt  = inexact_2;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            valid_o   <= 1'b0;
            Result_DO <= '0;
            OF_SO     <= 1'b0;
            UF_SO     <= 1'b0;
            NX_SO     <= 1'b0;
        end else if (en_2) begin
            valid_o <= valid_1;
            if (valid_1) begin
                Result_DO <= res_nxt;
                OF_SO     <= of_nxt;
                UF_SO     <= uf_nxt;
                NX_SO     <= nx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fmac_norm_round.sv
// Bench for fmac_norm_round: directed corner vectors with hand-computed
// results, backpressure and reset scenarios, then randomized traffic checked
// against an integer-arithmetic reference model.
module tb_fmac_norm_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_in = '0;
    logic [50:0] mant_in = '0;
    logic [5:0]  lead_in = '0;
    logic        noone_in = 1'b0;
    logic        rm_in = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [31:0] result;
    logic        of_flag, uf_flag, nx_flag;

    always #5 clk = ~clk;

    fmac_norm_round dut (
        .Clk_CI     (clk),
        .Rst_RI     (rst),
        .Valid_SI   (valid_in),
        .Ready_SO   (ready_out),
        .Sign_DI    (sign_in),
        .Exp_DI     (exp_in),
        .Mant_DI    (mant_in),
        .LeadOne_DI (lead_in),
        .NoOne_SI   (noone_in),
        .Rm_SI      (rm_in),
        .Valid_SO   (valid_out),
        .Ready_SI   (ready_in),
        .Result_DO  (result),
        .OF_SO      (of_flag),
        .UF_SO      (uf_flag),
        .NX_SO      (nx_flag)
    );

    typedef struct {
        logic [31:0] res;
        logic        of;
        logic        uf;
        logic        nx;
    } exp_t;

    typedef struct {
        bit          s;
        logic [9:0]  ex;
        logic [50:0] mt;
        logic [5:0]  ld;
        bit          no;
        bit          rm;
        exp_t        want;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    exp_t  q[$];
    exp_t  cur_want;
    bit    prev_hold = 1'b0;
    logic [31:0] prev_res = '0;
    logic [2:0]  prev_flags = '0;

    function automatic exp_t mk(logic [31:0] r, bit o, bit u, bit n);
        exp_t e;
        e.res = r; e.of = o; e.uf = u; e.nx = n;
        return e;
    endfunction

    // Reference: treat the magnitude as an integer, keep the top 24 bits as
    // the significand and round on the numeric value of the remainder.
    function automatic exp_t model(bit s, logic [9:0] ex, logic [50:0] mt,
                                   logic [5:0] ld, bit no, bit rm);
        exp_t r;
        longint unsigned m, sig, rem;
        longint unsigned half;
        int e;
        r = mk({s, 31'b0}, 1'b0, 1'b0, 1'b0);
        if (no) return r;
        m = {13'b0, mt};
        m = (m << ld) & ((64'd1 << 51) - 1);
        e = int'($signed(ex)) - int'(ld);
        if (e <= 0) begin
            r.uf = 1'b1; r.nx = 1'b1;
            return r;
        end
        half = 64'd1 << 26;
        sig  = m >> 27;
        rem  = m & ((64'd1 << 27) - 1);
        r.nx = (rem != 0);
        if (!rm && (rem > half || (rem == half && sig[0]))) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin
            sig = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            r.of = 1'b1; r.nx = 1'b1;
            r.res = rm ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
            return r;
        end
        r.res = {s, 8'(e), 23'(sig)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // One clock: check the output at the falling edge, then track what the
    // rising edge transfers in and out of the pipeline.
    task automatic tick(output bit acc);
        bit pop, rst_now;
        @(negedge clk);
        if (q.size() == 0) begin
            chk("no_spurious_valid", {63'b0, valid_out}, 64'd0);
        end else if (valid_out) begin
            chk("result", {32'b0, result}, {32'b0, q[0].res});
            chk("of", {63'b0, of_flag}, {63'b0, q[0].of});
            chk("uf", {63'b0, uf_flag}, {63'b0, q[0].uf});
            chk("nx", {63'b0, nx_flag}, {63'b0, q[0].nx});
        end
        if (prev_hold) begin
            chk("held_valid", {63'b0, valid_out}, 64'd1);
            chk("held_result", {32'b0, result}, {32'b0, prev_res});
            chk("held_flags", {61'b0, of_flag, uf_flag, nx_flag}, {61'b0, prev_flags});
        end
        rst_now    = rst;
        acc        = valid_in & ready_out & ~rst;
        pop        = valid_out & ready_in & ~rst;
        prev_hold  = valid_out & ~ready_in & ~rst;
        prev_res   = result;
        prev_flags = {of_flag, uf_flag, nx_flag};
        @(posedge clk);
        if (rst_now) begin
            q.delete();
        end else begin
            if (pop && q.size() > 0) q.delete(0);
            if (acc) q.push_back(cur_want);
        end
        #1;
    endtask

    task automatic drive(input vec_t v);
        valid_in = 1'b1;
        sign_in  = v.s;
        exp_in   = v.ex;
        mant_in  = v.mt;
        lead_in  = v.ld;
        noone_in = v.no;
        rm_in    = v.rm;
        cur_want = v.want;
    endtask

    task automatic send(input vec_t v, input bit rand_bp, output int n);
        bit acc;
        drive(v);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            if (rand_bp) ready_in = ($urandom_range(0, 3) != 0);
            tick(acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        valid_in = 1'b0;
        ready_in = 1'b1;
        n = 0;
        while ((q.size() != 0 || valid_out) && n < 100) begin
            tick(acc);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        logic [63:0] r;
        logic [50:0] one, mask;
        int ee;
        v.ld = 6'($urandom_range(0, 50));
        one  = 51'd1;
        mask = (one << (50 - int'(v.ld))) - 51'd1;
        r    = {$urandom, $urandom};
        v.mt = (one << (50 - int'(v.ld))) | (r[50:0] & mask);
        if ($urandom_range(0, 3) == 0) v.mt = v.mt & ~(mask >> 20);
        ee   = int'($urandom_range(0, 320)) - 20 + int'(v.ld);
        v.ex = 10'(ee);
        v.s  = 1'($urandom_range(0, 1));
        v.rm = 1'($urandom_range(0, 1));
        v.no = ($urandom_range(0, 15) == 0);
        if (v.no) v.mt = '0;
        v.want = model(v.s, v.ex, v.mt, v.ld, v.no, v.rm);
        return v;
    endfunction

    vec_t dir[$];

    function automatic vec_t dv(bit s, int ex, logic [50:0] mt, int ld, bit no, bit rm, exp_t w);
        vec_t v;
        v.s = s; v.ex = 10'(ex); v.mt = mt; v.ld = 6'(ld); v.no = no; v.rm = rm; v.want = w;
        return v;
    endfunction

    initial begin
        bit   acc;
        int   n;
        vec_t v;
        logic [50:0] ones;
        ones = {25'h1FFFFFF, 26'h0};

        dir.push_back(dv(0, 137, 51'd1 << 40, 10, 0, 0, mk(32'h3F800000, 0, 0, 0)));
        dir.push_back(dv(0, 127, (51'd1 << 50) | (51'd1 << 26), 0, 0, 0, mk(32'h3F800000, 0, 0, 1)));
        dir.push_back(dv(0, 127, (51'd1 << 50) | (51'd1 << 27) | (51'd1 << 26), 0, 0, 0, mk(32'h3F800002, 0, 0, 1)));
        dir.push_back(dv(0, 127, ones, 0, 0, 0, mk(32'h40000000, 0, 0, 1)));
        dir.push_back(dv(0, 254, ones, 0, 0, 0, mk(32'h7F800000, 1, 0, 1)));
        dir.push_back(dv(0, 254, ones, 0, 0, 1, mk(32'h7F7FFFFF, 0, 0, 1)));
        dir.push_back(dv(1, 5, 51'd1 << 40, 10, 0, 0, mk(32'h80000000, 0, 1, 1)));
        dir.push_back(dv(1, 200, 51'd0, 0, 1, 0, mk(32'h80000000, 0, 0, 0)));
        dir.push_back(dv(0, 1, 51'd1 << 50, 0, 0, 0, mk(32'h00800000, 0, 0, 0)));
        dir.push_back(dv(0, 0, 51'd1 << 50, 0, 0, 0, mk(32'h00000000, 0, 1, 1)));
        dir.push_back(dv(0, 255, 51'd1 << 50, 0, 0, 1, mk(32'h7F7FFFFF, 1, 0, 1)));
        dir.push_back(dv(0, 127, (51'd1 << 50) | (51'd1 << 27) | (51'd1 << 26), 0, 0, 1, mk(32'h3F800001, 0, 0, 1)));
        dir.push_back(dv(1, 128, 51'd1 << 50, 0, 0, 0, mk(32'hC0000000, 0, 0, 0)));
        dir.push_back(dv(0, 127, (51'd1 << 50) | (51'd1 << 26) | 51'd1, 0, 0, 0, mk(32'h3F800001, 0, 0, 1)));
        dir.push_back(dv(0, 254, 51'd1 << 50, 0, 0, 0, mk(32'h7F000000, 0, 0, 0)));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid", {63'b0, valid_out}, 64'd0);
        chk("reset_result", {32'b0, result}, 64'd0);
        chk("reset_flags", {61'b0, of_flag, uf_flag, nx_flag}, 64'd0);
        chk("reset_ready", {63'b0, ready_out}, 64'd1);

        // First result and its two-cycle latency
        send(dv(0, 127, 51'd1 << 50, 0, 0, 0, mk(32'h3F800000, 0, 0, 0)), 1'b0, n);
        valid_in = 1'b0;
        chk("latency_1", {63'b0, valid_out}, 64'd0);
        tick(acc);
        chk("latency_2", {63'b0, valid_out}, 64'd1);
        drain();

        // Directed corner vectors, back to back
        foreach (dir[i]) send(dir[i], 1'b0, n);
        drain();

        // Backpressure: two results held, upstream stalls, then all drain in order
        ready_in = 1'b0;
        send(rand_vec(), 1'b0, n);
        send(rand_vec(), 1'b0, n);
        v = rand_vec();
        drive(v);
        chk("bp_ready_drop", {63'b0, ready_out}, 64'd0);
        tick(acc);
        tick(acc);
        chk("bp_no_accept", {63'b0, acc}, 64'd0);
        ready_in = 1'b1;
        send(v, 1'b0, n);
        send(rand_vec(), 1'b0, n);
        for (int i = 0; i < 8; i++) begin
            send(rand_vec(), 1'b0, n);
            chk("stream_one_per_cycle", 64'(n), 64'd1);
        end
        drain();

        // Reset with both stages full; an input offered during reset is dropped
        ready_in = 1'b0;
        send(rand_vec(), 1'b0, n);
        send(rand_vec(), 1'b0, n);
        drive(rand_vec());
        rst = 1'b1;
        tick(acc);
        chk("midrst_valid", {63'b0, valid_out}, 64'd0);
        chk("midrst_result", {32'b0, result}, 64'd0);
        chk("midrst_flags", {61'b0, of_flag, uf_flag, nx_flag}, 64'd0);
        tick(acc);
        rst = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        chk("post_rst_ready", {63'b0, ready_out}, 64'd1);
        repeat (6) tick(acc);

        // Randomized traffic with random downstream stalls
        for (int i = 0; i < 300; i++) begin
            send(rand_vec(), 1'b1, n);
            if ($urandom_range(0, 4) == 0) begin
                valid_in = 1'b0;
                tick(acc);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
